// File: rtl/spi_arbiter_if.sv
// Bundle of requester-side and spi_master-side signals around the SPI arbiter.
// The arbiter connects through the slave modport; the system/bench side uses master.
interface spi_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 8
);
    logic                      arb_en;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ack;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic                      rsp_err;
    logic [NUM_REQ-1:0]        cs_n;
    logic                      m_start;
    logic [DATA_W-1:0]         m_tx_data;
    logic [DATA_W-1:0]         m_rx_data;
    logic                      m_done;
    logic                      busy;

    modport master (
        output arb_en, req_valid, req_data, m_rx_data, m_done,
        input  req_ack, rsp_valid, rsp_data, rsp_err, cs_n, m_start, m_tx_data, busy
    );

    modport slave (
        input  arb_en, req_valid, req_data, m_rx_data, m_done,
        output req_ack, rsp_valid, rsp_data, rsp_err, cs_n, m_start, m_tx_data, busy
    );
endinterface

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one spi_master among NUM_REQ requesters.
// One 8-bit transfer per grant, guarded by a watchdog; response returned to the winner.
module spi_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned TIMEOUT    = 64,
    parameter int unsigned GAP_CYCLES = 2
) (
    input logic          clk,
    input logic          rst_n,
    spi_arbiter_if.slave bus
);
    localparam int unsigned GW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned WW  = $clog2(TIMEOUT);
    localparam int unsigned GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {StIdle, StLaunch, StWait, StResp, StGap} state_e;

    state_e              state_q, state_d;
    logic [GW-1:0]       grant_q, grant_d;
    logic [GW-1:0]       ptr_q, ptr_d;
    logic [WW-1:0]       wdog_q, wdog_d;
    logic [GCW-1:0]      gap_q, gap_d;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [GW-1:0]        off;
    logic [GW:0]          sum;
    logic [GW-1:0]        win_idx;
    logic                 win_found;
    logic [DATA_W-1:0]    win_data;
    logic [NUM_REQ-1:0]   grant_oh;

    // Rotate requests so bit 0 is the ptr position, pick the lowest set bit, map back.
    always_comb begin
        dbl = {bus.req_valid, bus.req_valid} >> ptr_q;
        rot = dbl[NUM_REQ-1:0];
        off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = GW'(i);
        end
        win_found = |rot;
        sum = {1'b0, ptr_q} + {1'b0, off};
        win_idx = (int'(sum) >= NUM_REQ) ? GW'(int'(sum) - NUM_REQ) : sum[GW-1:0];
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == GW'(i)) win_data = bus.req_data[i*DATA_W +: DATA_W];
        end
    end

    // Next-state and datapath updates for the grant/transfer/response sequence.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        wdog_d     = wdog_q;
        gap_d      = gap_q;
        tx_d       = tx_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        unique case (state_q)
            StIdle: begin
                if (bus.arb_en && win_found) begin
                    grant_d = win_idx;
                    tx_d    = win_data;
                    state_d = StLaunch;
                end
            end
            StLaunch: begin
                wdog_d = '0;
                // A done arriving this early still belongs to the current transfer.
                if (bus.m_done) begin
                    rsp_data_d = bus.m_rx_data;
                    rsp_err_d  = 1'b0;
                    state_d    = StResp;
                end else begin
                    state_d = StWait;
                end
            end
            StWait: begin
                wdog_d = wdog_q + 1'b1;
                if (bus.m_done) begin
                    rsp_data_d = bus.m_rx_data;
                    rsp_err_d  = 1'b0;
                    state_d    = StResp;
                end else if (wdog_q == WW'(TIMEOUT - 1)) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = StResp;
                end
            end
            StResp: begin
                ptr_d   = (int'(grant_q) == NUM_REQ - 1) ? '0 : grant_q + 1'b1;
                gap_d   = '0;
                state_d = (GAP_CYCLES > 0) ? StGap : StIdle;
            end
            StGap: begin
                if (int'(gap_q) == GAP_CYCLES - 1) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            ptr_q      <= '0;
            wdog_q     <= '0;
            gap_q      <= '0;
            tx_q       <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            wdog_q     <= wdog_d;
            gap_q      <= gap_d;
            tx_q       <= tx_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // Outputs are decodes of registered state only.
    assign grant_oh      = NUM_REQ'(1) << grant_q;
    assign bus.m_start   = (state_q == StLaunch);
    assign bus.req_ack   = (state_q == StLaunch) ? grant_oh : '0;
    assign bus.rsp_valid = (state_q == StResp) ? grant_oh : '0;
    assign bus.cs_n      = (state_q == StLaunch || state_q == StWait || state_q == StResp) ?
                           ~grant_oh : '1;
    assign bus.busy      = (state_q != StIdle);
    assign bus.m_tx_data = tx_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter: single transfer, round-robin, timeout, done-on-timeout,
// enable/drop handling and asynchronous reset mid-transfer.
module tb_spi_arbiter;
    localparam int unsigned NUM_REQ    = 4;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned TIMEOUT    = 64;
    localparam int unsigned GAP_CYCLES = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   n_total = 0;
    int   n_pass  = 0;
    int   r;
    logic flag;

    spi_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

    spi_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_W     (DATA_W),
        .TIMEOUT    (TIMEOUT),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_total++;
        assert (obs === want) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    endtask

    // Wait (bounded) for the launch, check it, answer after dly wait cycles, check response.
    task automatic xfer(input string tag, input int idx, input logic [7:0] tx,
                        input logic [7:0] rx, input int dly, input logic [3:0] clr);
        int         n;
        logic       hold_ok;
        logic [3:0] oh;
        logic [3:0] cs_exp;
        oh     = 4'(1 << idx);
        cs_exp = ~oh;
        n      = 0;
        while (bus.m_start !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_start"}, 32'(bus.m_start), 1);
        chk({tag, "_ack"}, 32'(bus.req_ack), 32'(oh));
        chk({tag, "_tx"}, 32'(bus.m_tx_data), 32'(tx));
        chk({tag, "_cs_launch"}, 32'(bus.cs_n), 32'(cs_exp));
        bus.req_valid = bus.req_valid & ~clr;
        hold_ok = 1'b1;
        repeat (dly) begin
            @(negedge clk);
            if (bus.cs_n !== cs_exp || bus.rsp_valid !== 4'b0000) hold_ok = 1'b0;
        end
        chk({tag, "_wait_hold"}, 32'(hold_ok), 1);
        bus.m_done    = 1'b1;
        bus.m_rx_data = rx;
        @(negedge clk);
        bus.m_done = 1'b0;
        chk({tag, "_rspv"}, 32'(bus.rsp_valid), 32'(oh));
        chk({tag, "_rdata"}, 32'(bus.rsp_data), 32'(rx));
        chk({tag, "_rerr"}, 32'(bus.rsp_err), 0);
        chk({tag, "_cs_resp"}, 32'(bus.cs_n), 32'(cs_exp));
    endtask

    // Two gap cycles with all chip selects high, then idle.
    task automatic gap_chk(input string tag);
        @(negedge clk);
        chk({tag, "_gap1_cs"}, 32'(bus.cs_n), 32'hF);
        chk({tag, "_gap1_busy"}, 32'(bus.busy), 1);
        @(negedge clk);
        chk({tag, "_gap2_cs"}, 32'(bus.cs_n), 32'hF);
        chk({tag, "_gap2_busy"}, 32'(bus.busy), 1);
        @(negedge clk);
        chk({tag, "_idle_busy"}, 32'(bus.busy), 0);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.arb_en    = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.m_rx_data = '0;
        bus.m_done    = 1'b0;
        repeat (2) @(negedge clk);

        // Reset values
        chk("rst_ack", 32'(bus.req_ack), 0);
        chk("rst_rspv", 32'(bus.rsp_valid), 0);
        chk("rst_rdata", 32'(bus.rsp_data), 0);
        chk("rst_rerr", 32'(bus.rsp_err), 0);
        chk("rst_cs", 32'(bus.cs_n), 32'hF);
        chk("rst_start", 32'(bus.m_start), 0);
        chk("rst_tx", 32'(bus.m_tx_data), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single request from requester 2, reply after 20 cycles
        bus.arb_en    = 1'b1;
        bus.req_data  = 32'h00A5_0000;
        bus.req_valid = 4'b0100;
        @(negedge clk);
        chk("t1_latency", 32'(bus.m_start), 1);
        xfer("t1", 2, 8'hA5, 8'h3C, 20, 4'b0100);
        gap_chk("t1");

        // Round-robin from ptr=0 with every requester active
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.req_data  = 32'hD3C2_B1A0;
        bus.req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            r = i % 4;
            xfer("rr", r, 8'hA0 + 8'h11 * 8'(r), 8'h60 + 8'(i), 3, (i == 4) ? 4'hF : 4'h0);
            gap_chk("rr");
        end

        // Timeout on requester 1: m_done never comes
        bus.req_data  = 32'h0000_5A00;
        bus.req_valid = 4'b0010;
        @(negedge clk);
        chk("to_start", 32'(bus.m_start), 1);
        chk("to_ack", 32'(bus.req_ack), 32'h2);
        bus.req_valid = 4'b0000;
        flag = 1'b0;
        repeat (TIMEOUT) begin
            @(negedge clk);
            if (bus.rsp_valid !== 4'b0000) flag = 1'b1;
        end
        chk("to_not_early", 32'(flag), 0);
        @(negedge clk);
        chk("to_rspv", 32'(bus.rsp_valid), 32'h2);
        chk("to_rerr", 32'(bus.rsp_err), 1);
        chk("to_rdata", 32'(bus.rsp_data), 0);
        gap_chk("to");

        // Done on the same cycle as the last watchdog count: done wins
        bus.req_data  = 32'h00C3_0000;
        bus.req_valid = 4'b0100;
        xfer("dot", 2, 8'hC3, 8'h55, TIMEOUT, 4'b0100);
        gap_chk("dot");

        // arb_en dropped during WAIT: response completes, no further grant
        bus.req_data  = 32'h9900_0000;
        bus.req_valid = 4'b1000;
        @(negedge clk);
        chk("en_start", 32'(bus.m_start), 1);
        chk("en_ack", 32'(bus.req_ack), 32'h8);
        bus.req_valid = 4'b0001;
        bus.arb_en    = 1'b0;
        repeat (3) @(negedge clk);
        bus.m_done    = 1'b1;
        bus.m_rx_data = 8'h77;
        @(negedge clk);
        bus.m_done = 1'b0;
        chk("en_rspv", 32'(bus.rsp_valid), 32'h8);
        chk("en_rdata", 32'(bus.rsp_data), 32'h77);
        flag = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.m_start !== 1'b0 || bus.req_ack !== 4'b0000) flag = 1'b1;
        end
        chk("en_no_grant", 32'(flag), 0);
        chk("en_idle", 32'(bus.busy), 0);

        // Requester 0 drops before grant; requester 1 is served instead
        bus.req_data  = 32'h0000_B700;
        bus.req_valid = 4'b0010;
        bus.arb_en    = 1'b1;
        xfer("drop", 1, 8'hB7, 8'h42, 2, 4'b0010);
        gap_chk("drop");

        // Asynchronous reset during WAIT
        bus.req_data  = 32'h44E1_2200;
        bus.req_valid = 4'b0100;
        @(negedge clk);
        chk("rs_start", 32'(bus.m_start), 1);
        chk("rs_ack", 32'(bus.req_ack), 32'h4);
        bus.req_valid = 4'b0000;
        @(negedge clk);
        chk("rs_cs_wait", 32'(bus.cs_n), 32'hB);
        #2;
        rst_n         = 1'b0;
        bus.req_valid = 4'b1010;
        #1;
        chk("rs_cs_async", 32'(bus.cs_n), 32'hF);
        chk("rs_start_async", 32'(bus.m_start), 0);
        chk("rs_busy_async", 32'(bus.busy), 0);
        chk("rs_ack_async", 32'(bus.req_ack), 0);
        chk("rs_rdata_async", 32'(bus.rsp_data), 0);
        chk("rs_tx_async", 32'(bus.m_tx_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        // ptr back at 0: requester 1 before 3
        xfer("rs1", 1, 8'h22, 8'h5C, 2, 4'b0010);
        gap_chk("rs1");
        xfer("rs3", 3, 8'h44, 8'hC5, 2, 4'b1000);
        gap_chk("rs3");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
